// File: rtl/loader_pkg.sv
// ============================================================================
// Module  : loader_pkg
// Brief   : Shared state encoding and frame constants for the program loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package loader_pkg;

    localparam int HDR_LEN  = 2;
    localparam int CSUM_LEN = 1;

    typedef enum logic [2:0] {
        ST_LEN0 = 3'd0,
        ST_LEN1 = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_t;

    // States in which the loader is still consuming the byte stream.
    function automatic logic is_loading(input loader_state_t s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

    function automatic int frame_bytes(input int n_words);
        return HDR_LEN + 4 * n_words + CSUM_LEN;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prog_loader_byte_packer.sv
// ============================================================================
// Module  : byte_packer
// Brief   : Packs a byte stream little-endian into 32-bit words.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_last,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] pk_q, pk_d;
    logic        wv_q, wv_d;

    assign word_last  = byte_valid && !clear && (idx_q == 2'd3);
    assign word_valid = wv_q;
    assign word       = pk_q;

    // Each byte lands in its own lane, so the finished word is already in order.
    always_comb begin
        idx_d = idx_q;
        pk_d  = pk_q;
        wv_d  = 1'b0;
        if (clear) begin
            idx_d = 2'd0;
            pk_d  = 32'd0;
        end else if (byte_valid) begin
            idx_d              = idx_q + 2'd1;
            pk_d[8*idx_q +: 8] = byte_data;
            wv_d               = (idx_q == 2'd3);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 2'd0;
            pk_q  <= 32'd0;
            wv_q  <= 1'b0;
        end else begin
            idx_q <= idx_d;
            pk_q  <= pk_d;
            wv_q  <= wv_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module  : prog_loader
// Brief   : Loads a length/payload/checksum byte frame into instruction memory
//           and releases the core from reset once the frame checks out.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader
    import loader_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   restart,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   imem_we,
    output logic [AW-1:0]          imem_addr,
    output logic [31:0]            imem_wdata,
    output logic                   cpu_reset_n,
    output logic                   load_done,
    output logic                   load_error,
    output logic [$clog2(DEPTH):0] words_loaded
);

    localparam int WLW = $clog2(DEPTH) + 1;

    loader_state_t   state_q, state_d;
    logic [7:0]      len_lo_q, len_lo_d;
    logic [15:0]     len_q, len_d;
    logic [WLW-1:0]  wl_q, wl_d;
    logic [7:0]      xor_q, xor_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            cpu_rst_n_q, cpu_rst_n_d;

    logic            w_xfer;
    logic            w_pk_last;
    logic            w_pk_valid;
    logic [31:0]     w_pk_word;
    logic [15:0]     w_len_full;
    logic [15:0]     w_next_count;

    assign in_ready     = is_loading(state_q) && !restart;
    assign w_xfer       = in_valid && in_ready;
    assign w_len_full   = {in_data, len_lo_q};
    assign w_next_count = 16'(wl_q) + 16'd1;

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (reset),
        .clear      (restart),
        .byte_valid (w_xfer && (state_q == ST_DATA)),
        .byte_data  (in_data),
        .word_last  (w_pk_last),
        .word_valid (w_pk_valid),
        .word       (w_pk_word)
    );

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        wl_d     = wl_q;
        xor_d    = xor_q;
        addr_d   = addr_q;
        case (state_q)
            ST_LEN0: begin
                if (w_xfer) begin
                    len_lo_d = in_data;
                    state_d  = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (w_xfer) begin
                    len_d = w_len_full;
                    if (w_len_full == 16'd0) begin
                        state_d = ST_CSUM;
                    end else if (32'(w_len_full) > DEPTH) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_xfer) begin
                    xor_d = xor_q ^ in_data;
                end
                // Address and count advance together so the write carries the pre-increment index.
                if (w_pk_last) begin
                    wl_d   = wl_q + 1'b1;
                    addr_d = AW'({wl_q, 2'b00});
                    if (w_next_count == len_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (w_xfer) begin
                    state_d = (in_data == xor_q) ? ST_RUN : ST_ERR;
                end
            end
            default: ;
        endcase

        if (restart) begin
            state_d  = ST_LEN0;
            len_lo_d = 8'd0;
            len_d    = 16'd0;
            wl_d     = '0;
            xor_d    = 8'd0;
        end

        cpu_rst_n_d = (state_q == ST_RUN) && !restart;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_LEN0;
            len_lo_q    <= 8'd0;
            len_q       <= 16'd0;
            wl_q        <= '0;
            xor_q       <= 8'd0;
            addr_q      <= '0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            wl_q        <= wl_d;
            xor_q       <= xor_d;
            addr_q      <= addr_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    assign imem_we      = w_pk_valid;
    assign imem_wdata   = w_pk_word;
    assign imem_addr    = addr_q;
    assign cpu_reset_n  = cpu_rst_n_q;
    assign load_done    = (state_q == ST_RUN);
    assign load_error   = (state_q == ST_ERR);
    assign words_loaded = wl_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module  : tb_prog_loader
// Brief   : Self-checking bench for prog_loader against a frame-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

    localparam int DEPTH = 256;
    localparam int AW    = 32;
    localparam int WLW   = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           restart = 1'b0;
    logic           in_valid = 1'b0;
    logic [7:0]     in_data = 8'd0;
    logic           in_ready;
    logic           imem_we;
    logic [AW-1:0]  imem_addr;
    logic [31:0]    imem_wdata;
    logic           cpu_reset_n;
    logic           load_done;
    logic           load_error;
    logic [WLW-1:0] words_loaded;

    prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .restart      (restart),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset_n  (cpu_reset_n),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic [7:0]  frame_q[$];
    logic [7:0]  tx_q[$];
    wr_t         exp_wr[$];
    logic [31:0] seen_addr[$];
    logic [31:0] seen_data[$];
    int          run_edge = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Frame model: everything is derived from the byte positions of the frame received so far.
    function automatic int m_len();
        if (frame_q.size() < 2) return -1;
        return int'({frame_q[1], frame_q[0]});
    endfunction

    function automatic int m_status();   // 0 loading, 1 run, 2 error
        int n;
        logic [7:0] x;
        if (frame_q.size() < 2) return 0;
        n = m_len();
        if (n > DEPTH) return 2;
        if (frame_q.size() < 3 + 4 * n) return 0;
        x = 8'd0;
        for (int i = 2; i < 2 + 4 * n; i++) x ^= frame_q[i];
        return (frame_q[2 + 4 * n] == x) ? 1 : 2;
    endfunction

    function automatic int m_words();
        int n, k;
        if (frame_q.size() < 2) return 0;
        n = m_len();
        if (n > DEPTH) return 0;
        k = (frame_q.size() - 2) / 4;
        return (k < n) ? k : n;
    endfunction

    task automatic model_accept(input logic [7:0] b, input int c);
        int p, n;
        wr_t w;
        frame_q.push_back(b);
        p = frame_q.size() - 1;
        n = m_len();
        if (n >= 0 && n <= DEPTH && p >= 2 && p < 2 + 4 * n && (p - 2) % 4 == 3) begin
            w.addr = 32'(4 * ((p - 2) / 4));
            w.data = {frame_q[p], frame_q[p-1], frame_q[p-2], frame_q[p-3]};
            w.cyc  = c;
            exp_wr.push_back(w);
        end
        if (m_status() == 1 && run_edge < 0) run_edge = c;
    endtask

    task automatic model_clear();
        frame_q.delete();
        run_edge = -1;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("in_ready",     32'(in_ready),     32'(m_status() == 0 && !restart));
            chk("load_done",    32'(load_done),    32'(m_status() == 1));
            chk("load_error",   32'(load_error),   32'(m_status() == 2));
            chk("words_loaded", 32'(words_loaded), 32'(m_words()));
            chk("cpu_reset_n",  32'(cpu_reset_n),  32'(m_status() == 1 && run_edge >= 0 && cyc > run_edge));
            if (imem_we) begin
                seen_addr.push_back(imem_addr);
                seen_data.push_back(imem_wdata);
                if (exp_wr.size() == 0) begin
                    chk("spurious_we", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("we_addr",  imem_addr,  w.addr);
                    chk("we_data",  imem_wdata, w.data);
                    chk("we_cycle", 32'(cyc),   32'(w.cyc));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int k;
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            chk("byte_timeout", 32'd0, 32'd1);
            return;
        end
        @(posedge clk);
        #1;
        model_accept(b, cyc);
    endtask

    task automatic send_tx();
        foreach (tx_q[i]) send_byte(tx_q[i]);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        restart  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk);
        #1;
        model_clear();
        restart  = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"},    32'(imem_we),      32'd0);
        chk({tag, "_addr"},  imem_addr,         32'd0);
        chk({tag, "_wdata"}, imem_wdata,        32'd0);
        chk({tag, "_cpu"},   32'(cpu_reset_n),  32'd0);
        chk({tag, "_done"},  32'(load_done),    32'd0);
        chk({tag, "_err"},   32'(load_error),   32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready),     32'd1);
    endtask

    int n0;

    initial begin
        // Reset state.
        idle(3);
        chk_reset_outputs("rst");
        reset = 1'b1;
        idle(2);

        // Good two-word frame.
        n0 = seen_data.size();
        tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};
        send_tx();
        @(negedge clk);
        chk("good_done_first", 32'(load_done), 32'd1);
        chk("good_cpu_first",  32'(cpu_reset_n), 32'd0);
        @(negedge clk);
        chk("good_cpu_next",   32'(cpu_reset_n), 32'd1);
        chk("good_nwrites",    32'(seen_data.size() - n0), 32'd2);
        if (seen_data.size() >= n0 + 2) begin
            chk("good_w0_addr", seen_addr[n0],   32'h0);
            chk("good_w0_data", seen_data[n0],   32'h00500013);
            chk("good_w1_addr", seen_addr[n0+1], 32'h4);
            chk("good_w1_data", seen_data[n0+1], 32'h00100093);
        end
        chk("good_words", 32'(words_loaded), 32'd2);
        in_valid = 1'b1;
        in_data  = 8'h55;
        idle(3);
        in_valid = 1'b0;
        chk("good_held", 32'(load_done), 32'd1);
        chk("good_pending", 32'(exp_wr.size()), 32'd0);

        // Bad checksum.
        do_restart();
        chk("rs_words", 32'(words_loaded), 32'd0);
        n0 = seen_data.size();
        tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hC1};
        send_tx();
        in_valid = 1'b1;
        idle(3);
        in_valid = 1'b0;
        chk("bad_err",     32'(load_error), 32'd1);
        chk("bad_cpu",     32'(cpu_reset_n), 32'd0);
        chk("bad_nwrites", 32'(seen_data.size() - n0), 32'd2);

        // Oversized length.
        do_restart();
        n0 = seen_data.size();
        tx_q = '{8'h01, 8'h01};
        send_tx();
        @(negedge clk);
        chk("big_err",     32'(load_error), 32'd1);
        idle(2);
        chk("big_nwrites", 32'(seen_data.size() - n0), 32'd0);

        // Empty program.
        do_restart();
        n0 = seen_data.size();
        tx_q = '{8'h00, 8'h00, 8'h00};
        send_tx();
        idle(2);
        chk("zero_done",    32'(load_done), 32'd1);
        chk("zero_words",   32'(words_loaded), 32'd0);
        chk("zero_nwrites", 32'(seen_data.size() - n0), 32'd0);

        // Restart mid-frame, then a one-word frame.
        do_restart();
        tx_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_tx();
        do_restart();
        n0 = seen_data.size();
        tx_q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        send_tx();
        idle(2);
        chk("abort_nwrites", 32'(seen_data.size() - n0), 32'd1);
        if (seen_data.size() == n0 + 1) begin
            chk("abort_addr", seen_addr[n0], 32'h0);
            chk("abort_data", seen_data[n0], 32'hDEADBEEF);
        end
        chk("abort_done", 32'(load_done), 32'd1);

        // Asynchronous reset in DATA with a byte on the bus.
        do_restart();
        tx_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_tx();
        in_valid = 1'b1;
        in_data  = 8'h77;
        #1;
        reset = 1'b0;
        model_clear();
        #1;
        chk_reset_outputs("amid");
        chk("amid_pending", 32'(exp_wr.size()), 32'd0);
        in_valid = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);
        n0 = seen_data.size();
        tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};
        send_tx();
        idle(2);
        chk("reload_done",    32'(load_done), 32'd1);
        chk("reload_cpu",     32'(cpu_reset_n), 32'd1);
        chk("reload_nwrites", 32'(seen_data.size() - n0), 32'd2);
        chk("final_pending",  32'(exp_wr.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DEPTH, 256, instruction-memory capacity in 32-bit words.
REQ-002 Parameter AW, 32, width of imem_addr (byte address).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-005 restart  input  1  one-cycle pulse: abandon current state, return to LEN0, re-hold CPU in reset.
REQ-006 in_valid  input  1  byte-stream source has a byte.
REQ-007 in_data  input  8  byte-stream payload.
REQ-008 in_ready  output  1  loader accepts byte this cycle; transfer = in_valid & in_ready.
REQ-009 imem_we  output  1  one-cycle write strobe to instruction memory.
REQ-010 imem_addr  output  AW  word-aligned byte address, bits[1:0] always 00.
REQ-011 imem_wdata  output  32  assembled little-endian word.
REQ-012 cpu_reset_n  output  1  active-low reset to the pipelined core; high only after successful load.
REQ-013 load_done  output  1  high while in RUN.
REQ-014 load_error  output  1  high while in ERR.
REQ-015 words_loaded  output  $clog2(DEPTH)+1  count of words written in current frame.

Function
REQ-016 Frame format SHALL be: length low byte, length high byte (N words, 16 bits), 4*N payload bytes, 1 checksum byte = XOR of all payload bytes.
REQ-017 FSM states SHALL be LEN0, LEN1, DATA, CSUM, RUN, ERR.
REQ-018 in_ready SHALL be 1 in LEN0/LEN1/DATA/CSUM and restart=0; 0 otherwise.
REQ-019 LEN0 -> LEN1 on transfer; LEN1 -> DATA on transfer when 1<=N<=DEPTH, -> CSUM when N=0, -> ERR when N>DEPTH.
REQ-020 DATA: bytes packed little-endian (first byte -> bits[7:0]); on 4th byte transfer, imem_we SHALL pulse the next cycle for exactly one cycle with imem_addr=4*words_loaded(pre-increment), imem_wdata=packed word.
REQ-021 words_loaded SHALL increment in the same cycle imem_we is high; after word N is accepted the FSM SHALL enter CSUM.
REQ-022 Running XOR SHALL clear on entry to LEN0 and accumulate every payload byte.
REQ-023 CSUM: transfer with in_data == running XOR -> RUN; mismatch -> ERR.
REQ-024 cpu_reset_n SHALL be registered, rising the cycle after RUN is entered; 0 in all other states.
REQ-025 RUN and ERR SHALL be held indefinitely until restart or reset; in_valid ignored.
REQ-026 restart in any state SHALL next cycle yield LEN0, words_loaded=0, XOR=0, cpu_reset_n=0, partial word discarded, no imem_we.
REQ-027 restart coincident with in_valid SHALL win; the byte is not accepted.
REQ-028 imem_we SHALL never assert outside DATA-originated writes; no write after restart/reset for a discarded partial word.
REQ-029 Back-to-back bytes (in_valid held high) SHALL be accepted at one per cycle with no bubbles.

Reset
REQ-030 On reset=0: state LEN0, in_ready=1 after release, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset_n=0, load_done=0, load_error=0, words_loaded=0, XOR=0, byte index=0.
REQ-031 Reset mid-frame SHALL abort with no further memory writes; memory contents are not cleared.

Structure
REQ-032 Shared package loader_pkg SHALL hold the state enum loader_state_t and the frame constants (header length 2, checksum length 1).
REQ-033 Sub-module byte_packer SHALL hold the 2-bit byte index and 32-bit shift/packing register, with clear and word_valid outputs.

Verification
REQ-034 Frame 02 00 | 13 00 50 00 | 93 00 10 00 | C0 -> writes addr 0 data 0x00500013, addr 4 data 0x00100093, RUN, cpu_reset_n=1 one cycle after checksum.
REQ-035 Same frame with checksum 0xC1 -> two writes occur, ERR, load_error=1, cpu_reset_n stays 0.
REQ-036 Length 0x0101 (257 > DEPTH) -> ERR after second byte, zero imem_we pulses.
REQ-037 Length 00 00, checksum 00 -> RUN with words_loaded=0 and no writes.
REQ-038 restart after 6 payload bytes, then valid 1-word frame -> only the new word written at addr 0; no write from aborted partial word.
REQ-039 reset asserted during DATA with in_valid high -> all outputs at REQ-030 values in same cycle; reload succeeds afterwards.
